// File: rtl/pwm_update_ctrl.sv
// pwm_update_ctrl: shadowed span/compare registers for a PWM block, committed
// atomically at the carrier bottom so outputs never change mid-period.
// Build option: define PWM_RAMP_LIMIT_EN to slew-limit compare outputs by
// MAX_STEP per carrier period (adds the RAMP state); undefined = direct load.
module pwm_update_ctrl #(
   parameter logic [15:0] DEAD     = 16'h00f0,
   parameter logic [15:0] MAX_STEP = 16'h0100
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        Wr_En,
   input  logic [1:0]  Wr_Addr,
   input  logic [15:0] Wr_Data,
   output logic        Wr_Ack,
   input  logic        Down_in,
   output logic [15:0] Span_out,
   output logic [15:0] CntU_out,
   output logic [15:0] CntV_out,
   output logic        Busy,
   output logic        Upd_Strb
);

   localparam logic [15:0] SPAN_MAX = 16'hfffd - DEAD;
   localparam logic [15:0] RST_SPAN = 16'hff00;
   localparam logic [1:0]  A_SPAN   = 2'd0;
   localparam logic [1:0]  A_CNTU   = 2'd1;
   localparam logic [1:0]  A_CNTV   = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1
`ifdef PWM_RAMP_LIMIT_EN
      , RAMP = 2'd2
`endif
   } state_t;

   state_t      state_q, state_d;
   logic        down_q, down_d;
   logic        down_prev_q, down_prev_d;
   logic [15:0] span_sh_q, span_sh_d;
   logic [15:0] cntu_sh_q, cntu_sh_d;
   logic [15:0] cntv_sh_q, cntv_sh_d;
   logic [15:0] span_q, span_d;
   logic [15:0] cntu_q, cntu_d;
   logic [15:0] cntv_q, cntv_d;
   logic        ack_q, ack_d;
   logic        busy_q, busy_d;
   logic        upd_q, upd_d;

   logic        cb;
   logic        wr_ok;
   logic [15:0] tgt_u, tgt_v;
   logic [15:0] nxt_u, nxt_v;

   // carrier bottom: registered direction went down -> up
   assign cb    = down_prev_q & ~down_q;
   assign wr_ok = Wr_En & ~busy_q;

   // compare targets never exceed the committed span
   assign tgt_u = (cntu_sh_q < span_sh_q) ? cntu_sh_q : span_sh_q;
   assign tgt_v = (cntv_sh_q < span_sh_q) ? cntv_sh_q : span_sh_q;

`ifdef PWM_RAMP_LIMIT_EN
   // one slew-limited step toward tgt, 17-bit so neither direction wraps
   function automatic logic [15:0] step_to(input logic [15:0] cur, input logic [15:0] tgt);
      logic [16:0] up_sum;
      logic [16:0] tgt_sum;
      up_sum  = {1'b0, cur} + {1'b0, MAX_STEP};
      tgt_sum = {1'b0, tgt} + {1'b0, MAX_STEP};
      if (tgt >= cur) begin
         step_to = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[15:0];
      end else begin
         step_to = (tgt_sum >= {1'b0, cur}) ? tgt : 16'(cur - MAX_STEP);
      end
   endfunction

   assign nxt_u = step_to(cntu_q, tgt_u);
   assign nxt_v = step_to(cntv_q, tgt_v);
`else
   assign nxt_u = tgt_u;
   assign nxt_v = tgt_v;

   // the step limit has no effect without the slew limiter
   if (MAX_STEP != 16'h0000) begin : g_step_unused
   end
`endif

   // host writes, commit FSM and carrier-bottom update
   always_comb begin
      state_d     = state_q;
      down_d      = Down_in;
      down_prev_d = down_q;
      span_sh_d   = span_sh_q;
      cntu_sh_d   = cntu_sh_q;
      cntv_sh_d   = cntv_sh_q;
      span_d      = span_q;
      cntu_d      = cntu_q;
      cntv_d      = cntv_q;
      ack_d       = 1'b0;
      upd_d       = 1'b0;

      if (wr_ok) begin
         ack_d = 1'b1;
         case (Wr_Addr)
            A_SPAN:  span_sh_d = (Wr_Data > SPAN_MAX) ? SPAN_MAX : Wr_Data;
            A_CNTU:  cntu_sh_d = Wr_Data;
            A_CNTV:  cntv_sh_d = Wr_Data;
            default: ;
         endcase
      end

      case (state_q)
         IDLE: begin
            // a CB coinciding with the commit is ignored; update waits a period
            if (wr_ok && (Wr_Addr == 2'd3)) state_d = PEND;
         end
         default: begin
            if (cb) begin
               span_d  = span_sh_q;
               cntu_d  = nxt_u;
               cntv_d  = nxt_v;
               upd_d   = 1'b1;
`ifdef PWM_RAMP_LIMIT_EN
               state_d = ((nxt_u == tgt_u) && (nxt_v == tgt_v)) ? IDLE : RAMP;
`else
               state_d = IDLE;
`endif
            end
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // state and output registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         down_q      <= 1'b0;
         down_prev_q <= 1'b0;
         span_sh_q   <= RST_SPAN;
         cntu_sh_q   <= 16'h0000;
         cntv_sh_q   <= 16'h0000;
         span_q      <= RST_SPAN;
         cntu_q      <= 16'h0000;
         cntv_q      <= 16'h0000;
         ack_q       <= 1'b0;
         busy_q      <= 1'b0;
         upd_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         down_q      <= down_d;
         down_prev_q <= down_prev_d;
         span_sh_q   <= span_sh_d;
         cntu_sh_q   <= cntu_sh_d;
         cntv_sh_q   <= cntv_sh_d;
         span_q      <= span_d;
         cntu_q      <= cntu_d;
         cntv_q      <= cntv_d;
         ack_q       <= ack_d;
         busy_q      <= busy_d;
         upd_q       <= upd_d;
      end
   end

   assign Wr_Ack   = ack_q;
   assign Span_out = span_q;
   assign CntU_out = cntu_q;
   assign CntV_out = cntv_q;
   assign Busy     = busy_q;
   assign Upd_Strb = upd_q;

endmodule

// File: tb/tb_pwm_update_ctrl.sv
// Directed bench for pwm_update_ctrl: a vector table for write/commit/CB
// behaviour plus hand sequences for ramping, commit+CB collision and reset.
module tb_pwm_update_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [15:0] wr_data;
   logic        down_in;
   logic        Wr_Ack, Busy, Upd_Strb;
   logic [15:0] Span_out, CntU_out, CntV_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pwm_update_ctrl dut (
      .CLK      (clk),
      .RST      (rst),
      .Wr_En    (wr_en),
      .Wr_Addr  (wr_addr),
      .Wr_Data  (wr_data),
      .Wr_Ack   (Wr_Ack),
      .Down_in  (down_in),
      .Span_out (Span_out),
      .CntU_out (CntU_out),
      .CntV_out (CntV_out),
      .Busy     (Busy),
      .Upd_Strb (Upd_Strb)
   );

   typedef struct {
      bit          is_cb;
      logic [1:0]  addr;
      logic [15:0] data;
      logic        ack;
      logic [15:0] span;
      logic [15:0] u;
      logic [15:0] v;
      logic        busy;
   } vec_t;

   localparam int unsigned NV = 18;
   vec_t vec [NV];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chk_outs(input string nm, input logic [15:0] s, input logic [15:0] u,
                           input logic [15:0] v, input logic b);
      chk({nm, "_span"}, Span_out, s);
      chk({nm, "_cntu"}, CntU_out, u);
      chk({nm, "_cntv"}, CntV_out, v);
      chk({nm, "_busy"}, 16'(Busy), 16'(b));
   endtask

   // one-cycle write strobe; ends on the negedge after the capturing edge
   task automatic wr(input string nm, input logic [1:0] a, input logic [15:0] d, input logic ack);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(posedge clk);
      @(negedge clk);
      wr_en = 1'b0;
      chk({nm, "_ack"}, 16'(Wr_Ack), 16'(ack));
   endtask

   // carrier period ending at the bottom; returns on the update cycle
   task automatic cb_pulse(input string nm);
      down_in = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      down_in = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_early_upd"}, 16'(Upd_Strb), 16'h0000);
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_upd"}, 16'(Upd_Strb), 16'h0001);
   endtask

   task automatic cb_check(input string nm, input logic [15:0] s, input logic [15:0] u,
                           input logic [15:0] v, input logic b);
      cb_pulse(nm);
      chk_outs(nm, s, u, v, b);
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_upd_single"}, 16'(Upd_Strb), 16'h0000);
   endtask

   initial begin
      //          cb  addr  data      ack  span      cntu      cntv      busy
      vec[0]  = '{0, 2'd0, 16'h8000, 1'b1, 16'hff00, 16'h0000, 16'h0000, 1'b0};
      vec[1]  = '{0, 2'd1, 16'h0080, 1'b1, 16'hff00, 16'h0000, 16'h0000, 1'b0};
      vec[2]  = '{0, 2'd3, 16'h0000, 1'b1, 16'hff00, 16'h0000, 16'h0000, 1'b1};
      vec[3]  = '{0, 2'd1, 16'h2222, 1'b0, 16'hff00, 16'h0000, 16'h0000, 1'b1};
      vec[4]  = '{0, 2'd3, 16'h0000, 1'b0, 16'hff00, 16'h0000, 16'h0000, 1'b1};
      vec[5]  = '{1, 2'd0, 16'h0000, 1'b0, 16'h8000, 16'h0080, 16'h0000, 1'b0};
      vec[6]  = '{0, 2'd0, 16'hffff, 1'b1, 16'h8000, 16'h0080, 16'h0000, 1'b0};
      vec[7]  = '{0, 2'd3, 16'h0000, 1'b1, 16'h8000, 16'h0080, 16'h0000, 1'b1};
      vec[8]  = '{1, 2'd0, 16'h0000, 1'b0, 16'hff0d, 16'h0080, 16'h0000, 1'b0};
      vec[9]  = '{0, 2'd0, 16'h0050, 1'b1, 16'hff0d, 16'h0080, 16'h0000, 1'b0};
      vec[10] = '{0, 2'd2, 16'h9000, 1'b1, 16'hff0d, 16'h0080, 16'h0000, 1'b0};
      vec[11] = '{0, 2'd3, 16'h0000, 1'b1, 16'hff0d, 16'h0080, 16'h0000, 1'b1};
      vec[12] = '{1, 2'd0, 16'h0000, 1'b0, 16'h0050, 16'h0050, 16'h0050, 1'b0};
      vec[13] = '{0, 2'd0, 16'hff0e, 1'b1, 16'h0050, 16'h0050, 16'h0050, 1'b0};
      vec[14] = '{0, 2'd1, 16'h0000, 1'b1, 16'h0050, 16'h0050, 16'h0050, 1'b0};
      vec[15] = '{0, 2'd2, 16'h0050, 1'b1, 16'h0050, 16'h0050, 16'h0050, 1'b0};
      vec[16] = '{0, 2'd3, 16'h0000, 1'b1, 16'h0050, 16'h0050, 16'h0050, 1'b1};
      vec[17] = '{1, 2'd0, 16'h0000, 1'b0, 16'hff0d, 16'h0000, 16'h0050, 1'b0};

      rst     = 1'b1;
      wr_en   = 1'b0;
      wr_addr = 2'd0;
      wr_data = 16'h0000;
      down_in = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_outs("reset", 16'hff00, 16'h0000, 16'h0000, 1'b0);
      chk("reset_ack", 16'(Wr_Ack), 16'h0000);
      chk("reset_upd", 16'(Upd_Strb), 16'h0000);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < int'(NV); i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         if (vec[i].is_cb) begin
            cb_check(nm, vec[i].span, vec[i].u, vec[i].v, vec[i].busy);
         end else begin
            wr(nm, vec[i].addr, vec[i].data, vec[i].ack);
            chk_outs(nm, vec[i].span, vec[i].u, vec[i].v, vec[i].busy);
         end
      end

      // asynchronous reset; shadows must return to the reset outputs too
      #2 rst = 1'b1;
      #1 chk_outs("rst2", 16'hff00, 16'h0000, 16'h0000, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      wr("shadow_commit", 2'd3, 16'h0000, 1'b1);
      cb_check("shadow_reset", 16'hff00, 16'h0000, 16'h0000, 1'b0);

      // ramp up 0 -> 0350
      wr("ramp_wr", 2'd1, 16'h0350, 1'b1);
      wr("ramp_commit", 2'd3, 16'h0000, 1'b1);
`ifdef PWM_RAMP_LIMIT_EN
      cb_check("ramp1", 16'hff00, 16'h0100, 16'h0000, 1'b1);
      cb_check("ramp2", 16'hff00, 16'h0200, 16'h0000, 1'b1);
      cb_check("ramp3", 16'hff00, 16'h0300, 16'h0000, 1'b1);
      cb_check("ramp4", 16'hff00, 16'h0350, 16'h0000, 1'b0);
`else
      cb_check("ramp1", 16'hff00, 16'h0350, 16'h0000, 1'b0);
`endif

      // ramp down 0350 -> 0200
      wr("dec_wr", 2'd1, 16'h0200, 1'b1);
      wr("dec_commit", 2'd3, 16'h0000, 1'b1);
`ifdef PWM_RAMP_LIMIT_EN
      cb_check("dec1", 16'hff00, 16'h0250, 16'h0000, 1'b1);
`endif
      cb_check("dec2", 16'hff00, 16'h0200, 16'h0000, 1'b0);

      // commit lands in the same cycle as the registered CB
      wr("coll_wr", 2'd1, 16'h0100, 1'b1);
      down_in = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      down_in = 1'b0;
      @(posedge clk);
      @(negedge clk);
      wr("coll_commit", 2'd3, 16'h0000, 1'b1);
      chk("coll_upd", 16'(Upd_Strb), 16'h0000);
      chk_outs("coll", 16'hff00, 16'h0200, 16'h0000, 1'b1);
      @(posedge clk);
      @(negedge clk);
      chk("coll_upd_late", 16'(Upd_Strb), 16'h0000);
      cb_check("coll_next", 16'hff00, 16'h0100, 16'h0000, 1'b0);

      // reset while a commit is in flight
      wr("rmid_wr", 2'd1, 16'h0500, 1'b1);
      wr("rmid_commit", 2'd3, 16'h0000, 1'b1);
`ifdef PWM_RAMP_LIMIT_EN
      cb_check("rmid_step", 16'hff00, 16'h0200, 16'h0000, 1'b1);
`else
      chk("rmid_busy_pre", 16'(Busy), 16'h0001);
`endif
      #2 rst = 1'b1;
      #1 chk_outs("rmid", 16'hff00, 16'h0000, 16'h0000, 1'b0);
      chk("rmid_upd", 16'(Upd_Strb), 16'h0000);
      chk("rmid_ack", 16'(Wr_Ack), 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk_outs("rmid_after", 16'hff00, 16'h0000, 16'h0000, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
